ex_muldiv: RTL and testbench

- Iterative RV32M multiply/divide execution unit. It sits beside the single-cycle execute ALU in the EX stage.
- Accepts one M-extension op at a time from ID/EX. Computes it over multiple cycles. Returns result, destination register and write enable to EX/MEM with a done pulse.
- Stalls the pipeline through busy. Squashable by the branch-mispredict flush.

---
 rtl/ex_muldiv.sv | 161 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: one op at a time,
// BITS_PER_CYCLE result bits per iteration, registered outputs, flushable.
module ex_muldiv #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int OPLEN          = 3,
  parameter int REGADDR        = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               start,
  input  logic [OPLEN-1:0]   op,
  input  logic [XLEN-1:0]    rs1,
  input  logic [XLEN-1:0]    rs2,
  input  logic [REGADDR-1:0] rd_addr_i,
  input  logic               rd_enable_i,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result,
  output logic [REGADDR-1:0] rd_addr_o,
  output logic               rd_enable_o
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [OPLEN-1:0] OP_MUL    = OPLEN'(0);
  localparam logic [OPLEN-1:0] OP_MULH   = OPLEN'(1);
  localparam logic [OPLEN-1:0] OP_MULHSU = OPLEN'(2);
  localparam logic [OPLEN-1:0] OP_MULHU  = OPLEN'(3);
  localparam logic [OPLEN-1:0] OP_DIV    = OPLEN'(4);
  localparam logic [OPLEN-1:0] OP_DIVU   = OPLEN'(5);
  localparam logic [OPLEN-1:0] OP_REM    = OPLEN'(6);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_next;

  logic [OPLEN-1:0] op_q;
  logic [XLEN-1:0]  hi, lo, opnd;
  logic             neg_q, neg_r, rd_enable_q;
  logic [CW-1:0]    cnt;

  logic            accept, last_iter, is_div, a_signed, b_signed;
  logic            rs1_neg, rs2_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0] rs1_mag, rs2_mag, special_result;
  logic [XLEN-1:0] h, l, hi_step, lo_step, quo, rem, final_result;
  logic [XLEN:0]   sum, shifted;
  logic [2*XLEN-1:0] prod;

  // Operand decode at acceptance: magnitudes, sign flags and divide special cases.
  always_comb begin
    is_div   = op[2];
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    rs1_neg  = a_signed & rs1[XLEN-1];
    rs2_neg  = b_signed & rs2[XLEN-1];
    rs1_mag  = rs1_neg ? -rs1 : rs1;
    rs2_mag  = rs2_neg ? -rs2 : rs2;
    div_zero = is_div && (rs2 == '0);
    div_ovf  = is_div && !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_result = op[1] ? rs1 : '1;
    else          special_result = op[1] ? '0 : rs1;
  end

  always_comb begin
    accept     = start && !flush && (state != CALC);
    last_iter  = (cnt == CW'(N - 1));
    state_next = state;
    case (state)
      IDLE, DONE: state_next = accept ? (special ? DONE : CALC) : IDLE;
      CALC: begin
        if (flush)          state_next = IDLE;
        else if (last_iter) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // hi/lo hold accumulator+multiplier for multiplies, remainder+quotient for divides.
  always_comb begin
    h       = hi;
    l       = lo;
    sum     = '0;
    shifted = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q[2]) begin
        shifted = {h, l[XLEN-1]};
        l       = {l[XLEN-2:0], 1'b0};
        if (shifted >= {1'b0, opnd}) begin
          shifted = shifted - {1'b0, opnd};
          l[0]    = 1'b1;
        end
        h = shifted[XLEN-1:0];
      end else begin
        sum = {1'b0, h} + (l[0] ? {1'b0, opnd} : '0);
        l   = {sum[0], l[XLEN-1:1]};
        h   = sum[XLEN:1];
      end
    end
    hi_step = h;
    lo_step = l;
  end

  always_comb begin
    prod = {hi_step, lo_step};
    if (neg_q) prod = -prod;
    quo = neg_q ? -lo_step : lo_step;
    rem = neg_r ? -hi_step : hi_step;
    case (op_q)
      OP_MUL:                       final_result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_result = quo;
      default:                      final_result = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      rd_addr_o   <= '0;
      rd_enable_o <= 1'b0;
      rd_enable_q <= 1'b0;
      cnt         <= '0;
      op_q        <= '0;
      hi          <= '0;
      lo          <= '0;
      opnd        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      state       <= state_next;
      busy        <= (state_next == CALC);
      done        <= (state_next == DONE);
      rd_enable_o <= (state_next == DONE) && (accept ? rd_enable_i : rd_enable_q);
      if (accept) begin
        op_q        <= op;
        rd_addr_o   <= rd_addr_i;
        rd_enable_q <= rd_enable_i;
        cnt         <= '0;
        neg_q       <= rs1_neg ^ rs2_neg;
        neg_r       <= rs1_neg;
        hi          <= '0;
        opnd        <= is_div ? rs2_mag : rs1_mag;
        lo          <= is_div ? rs1_mag : rs2_mag;
        if (special) result <= special_result;
      end else if (state == CALC) begin
        hi  <= hi_step;
        lo  <= lo_step;
        cnt <= cnt + CW'(1);
        if (last_iter && !flush) result <= final_result;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized bench for ex_muldiv: a 1-bit/cycle and a 4-bit/cycle instance are
// checked against a plain-arithmetic RV32M reference model.
module tb_ex_muldiv;

  localparam int XLEN  = 32;
  localparam int NLAT  = XLEN + 1;
  localparam int NLAT4 = XLEN / 4 + 1;

  logic        clk = 1'b0;
  logic        rst, flush, start, start4, flush4;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_addr_i;
  logic        rd_enable_i;

  logic        busy, done, rd_enable_o;
  logic [31:0] result;
  logic [4:0]  rd_addr_o;
  logic        busy4, done4, rd_enable_o4;
  logic [31:0] result4;
  logic [4:0]  rd_addr_o4;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] last_result = '0;

  ex_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1), .OPLEN(3), .REGADDR(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .rs1(rs1), .rs2(rs2), .rd_addr_i(rd_addr_i), .rd_enable_i(rd_enable_i),
    .busy(busy), .done(done), .result(result),
    .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o)
  );

  ex_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4), .OPLEN(3), .REGADDR(5)) dut4 (
    .clk(clk), .rst(rst), .flush(flush4), .start(start4), .op(op),
    .rs1(rs1), .rs2(rs2), .rd_addr_i(rd_addr_i), .rd_enable_i(rd_enable_i),
    .busy(busy4), .done(done4), .result(result4),
    .rd_addr_o(rd_addr_o4), .rd_enable_o(rd_enable_o4)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // RV32M semantics straight from the ISA rules using 64-bit integer arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int            ia, ib;
    longint        sa, sb;
    longint unsigned ua, ub;
    logic [63:0]   p;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit isSpecial(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 0) || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic applyStimulus(input bit wide, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rda, input logic rde);
    op = o; rs1 = a; rs2 = b; rd_addr_i = rda; rd_enable_i = rde;
    if (wide) start4 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start4 = 1'b0;
  endtask

  // Watches busy/done from cycle c0 and checks latency, busy profile and outputs.
  task automatic observe(input string tag, input bit wide, input int c0, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rda, input logic rde);
    int          lat, done_at, busy_err;
    logic        b_now, d_now;
    logic [31:0] exp;
    lat      = isSpecial(o, a, b) ? 1 : (wide ? NLAT4 : NLAT);
    exp      = refModel(o, a, b);
    done_at  = 0;
    busy_err = 0;
    for (int c = c0; c <= NLAT + 10; c++) begin
      b_now = wide ? busy4 : busy;
      d_now = wide ? done4 : done;
      if (b_now !== ((c < lat) ? 1'b1 : 1'b0)) busy_err++;
      if (d_now === 1'b1) begin
        done_at = c;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, " latency"}, done_at, lat);
    checkOutput({tag, " busy"}, busy_err, 0);
    checkOutput({tag, " result"}, wide ? result4 : result, exp);
    checkOutput({tag, " rd_addr"}, wide ? rd_addr_o4 : rd_addr_o, rda);
    checkOutput({tag, " rd_enable"}, wide ? rd_enable_o4 : rd_enable_o, rde);
    if (!wide) last_result = exp;
  endtask

  task automatic checkPulse(input string tag);
    @(negedge clk);
    checkOutput({tag, " done pulse"}, {busy, done, rd_enable_o}, 3'b000);
  endtask

  task automatic countDone(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
  endtask

  logic [2:0]  d_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a  [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] d_b  [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [4:0]  rda;
    logic        rde;
    int          seen;

    rst = 1'b1; flush = 1'b0; flush4 = 1'b0; start = 1'b0; start4 = 1'b0;
    op = '0; rs1 = '0; rs2 = '0; rd_addr_i = '0; rd_enable_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset state", {busy, done, rd_enable_o, rd_addr_o, result}, 0);
    checkOutput("reset state x4", {busy4, done4, rd_enable_o4, rd_addr_o4, result4}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, d_op[i], d_a[i], d_b[i], 5'd5, 1'b1);
      observe($sformatf("dir%0d", i), 1'b0, 1, d_op[i], d_a[i], d_b[i], 5'd5, 1'b1);
      checkPulse($sformatf("dir%0d", i));
    end

    applyStimulus(1'b0, 3'd0, 32'd9, 32'd9, 5'd17, 1'b0);
    observe("no write", 1'b0, 1, 3'd0, 32'd9, 32'd9, 5'd17, 1'b0);
    checkPulse("no write");

    applyStimulus(1'b0, 3'd1, 32'h12345678, 32'hF0000001, 5'd3, 1'b1);
    repeat (3) @(negedge clk);
    op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; rd_addr_i = 5'd30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    observe("start busy", 1'b0, 5, 3'd1, 32'h12345678, 32'hF0000001, 5'd3, 1'b1);
    checkPulse("start busy");

    applyStimulus(1'b0, 3'd4, 32'hFFFFFC18, 32'd7, 5'd8, 1'b1);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush idle", {busy, done, rd_enable_o}, 3'b000);
    countDone(40, seen);
    checkOutput("flush no done", seen, 0);
    checkOutput("flush result held", result, last_result);

    op = 3'd0; rs1 = 32'd3; rs2 = 32'd4; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checkOutput("start flush busy", busy, 1'b0);
    countDone(36, seen);
    checkOutput("start flush no done", seen, 0);

    applyStimulus(1'b0, 3'd0, 32'd7, 32'hFFFFFFFD, 5'd11, 1'b1);
    observe("b2b first", 1'b0, 1, 3'd0, 32'd7, 32'hFFFFFFFD, 5'd11, 1'b1);
    applyStimulus(1'b0, 3'd0, 32'hDEADBEEF, 32'h00C0FFEE, 5'd12, 1'b1);
    observe("b2b second", 1'b0, 1, 3'd0, 32'hDEADBEEF, 32'h00C0FFEE, 5'd12, 1'b1);
    checkPulse("b2b second");

    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7)); a = randOperand(); b = randOperand();
      rda = 5'($urandom_range(0, 31)); rde = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, o, a, b, rda, rde);
      observe($sformatf("rand%0d op%0d", i, o), 1'b0, 1, o, a, b, rda, rde);
      checkPulse($sformatf("rand%0d", i));
    end

    applyStimulus(1'b1, 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 1'b1);
    observe("x4 mul", 1'b1, 1, 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      o = 3'($urandom_range(0, 7)); a = randOperand(); b = randOperand();
      rda = 5'($urandom_range(0, 31));
      @(negedge clk);
      applyStimulus(1'b1, o, a, b, rda, 1'b1);
      observe($sformatf("x4 rand%0d op%0d", i, o), 1'b1, 1, o, a, b, rda, 1'b1);
    end

    @(negedge clk);
    applyStimulus(1'b0, 3'd2, 32'h7FFFFFFF, 32'h00001234, 5'd21, 1'b1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset mid calc", {busy, done, rd_enable_o, rd_addr_o, result}, 0);
    rst = 1'b0;
    countDone(40, seen);
    checkOutput("reset mid no done", seen, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
